mem_buff_drain: RTL and testbench

- Read-side initiator for the 512x16 FFT sample buffer (mem_buff).
- On a start pulse it walks buffer addresses 0..DEPTH-1, issuing one read per sample and capturing the returned sample.
- It presents the captured samples in address order on a valid/ready stream to the downstream consumer (output serializer or SRAM write-back path).
- It never writes the buffer; it only drives the buffer's read-enable and address.

---
 rtl/mem_buff_drain.sv | 127 ++++++++++++
 tb/tb_mem_buff_drain.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_buff_drain.sv
// rtl/mem_buff_drain.sv - walks the FFT sample buffer 0..DEPTH-1 and streams each sample out in order
module mem_buff_drain #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    output logic              sram_read_ena,
    output logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        HOLD,
        DONE
    } state_t;

    // Final index found by compare, so DEPTH == 2**ADDR_W never needs the counter to wrap.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;
    logic [ADDR_W-1:0] address_nxt;
    logic [DATA_W-1:0] out_data_nxt;
    logic              read_ena_nxt;
    logic              out_valid_nxt;
    logic              out_last_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              at_last;

    assign at_last = (cnt == LAST_IDX);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            cnt           <= '0;
            sram_read_ena <= 1'b0;
            address       <= '0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            sram_read_ena <= read_ena_nxt;
            address       <= address_nxt;
            out_data      <= out_data_nxt;
            out_valid     <= out_valid_nxt;
            out_last      <= out_last_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
        end
    end

    // Every output is computed one state ahead so it lands registered in the state it belongs to.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        address_nxt   = address;
        out_data_nxt  = out_data;
        read_ena_nxt  = 1'b0;
        out_valid_nxt = out_valid;
        out_last_nxt  = out_last;
        busy_nxt      = busy;
        done_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = READ;
                    cnt_nxt      = '0;
                    address_nxt  = '0;
                    read_ena_nxt = 1'b1;
                    busy_nxt     = 1'b1;
                end
            end
            READ: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                state_nxt     = HOLD;
                out_data_nxt  = sample;
                out_valid_nxt = 1'b1;
                out_last_nxt  = at_last;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    out_last_nxt  = 1'b0;
                    if (at_last) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt    = READ;
                        cnt_nxt      = cnt + 1'b1;
                        address_nxt  = cnt + 1'b1;
                        read_ena_nxt = 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_buff_drain.sv
// tb/tb_mem_buff_drain.sv - directed bench for mem_buff_drain (DEPTH=512 and DEPTH=4 instances)
module tb_mem_buff_drain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst;
    logic        start;
    logic        out_ready;
    logic        sram_read_ena;
    logic [9:0]  address;
    logic [15:0] sample;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        busy;
    logic        done;

    logic        s_start;
    logic        s_ready;
    logic        s_read_ena;
    logic [1:0]  s_address;
    logic [15:0] s_sample;
    logic [15:0] s_out_data;
    logic        s_out_valid;
    logic        s_out_last;
    logic        s_busy;
    logic        s_done;

    mem_buff_drain #(.DATA_W(16), .ADDR_W(10), .DEPTH(512)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .sram_read_ena(sram_read_ena),
        .address(address), .sample(sample), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
    );

    mem_buff_drain #(.DATA_W(16), .ADDR_W(2), .DEPTH(4)) dut_s (
        .clk(clk), .n_rst(n_rst), .start(s_start), .sram_read_ena(s_read_ena),
        .address(s_address), .sample(s_sample), .out_data(s_out_data), .out_valid(s_out_valid),
        .out_ready(s_ready), .out_last(s_out_last), .busy(s_busy), .done(s_done)
    );

    // Buffer models: data is only meaningful the cycle after a read strobe, junk otherwise.
    always @(posedge clk) begin
        sample   <= sram_read_ena ? {6'd0, address} : (16'h8000 | 16'($urandom));
        s_sample <= s_read_ena ? (16'hA000 + {14'd0, s_address}) : (16'h5000 ^ 16'($urandom_range(0, 255)));
    end

    int          rd_cnt = 0, rd_multi = 0, hs_cnt = 0, last_cnt = 0, done_cnt = 0;
    logic [15:0] last_val = '0;
    logic        prev_rd = 1'b0;
    logic [15:0] got[$];
    int          s_rd_cnt = 0, s_hs_cnt = 0, s_last_cnt = 0, s_done_cnt = 0;
    logic [15:0] s_last_val = '0;
    logic [15:0] s_got[$];

    always @(negedge clk) begin
        if (sram_read_ena === 1'b1) begin
            rd_cnt++;
            if (prev_rd === 1'b1) rd_multi++;
        end
        prev_rd = sram_read_ena;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            hs_cnt++;
            got.push_back(out_data);
            if (out_last === 1'b1) begin
                last_cnt++;
                last_val = out_data;
            end
        end
        if (done === 1'b1) done_cnt++;
        if (s_read_ena === 1'b1) s_rd_cnt++;
        if (s_out_valid === 1'b1 && s_ready === 1'b1) begin
            s_hs_cnt++;
            s_got.push_back(s_out_data);
            if (s_out_last === 1'b1) begin
                s_last_cnt++;
                s_last_val = s_out_data;
            end
        end
        if (s_done === 1'b1) s_done_cnt++;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_seq(input string tag, input logic [15:0] q[$], input int base,
                           input int len, input logic [15:0] first);
        int errs = 0;
        chk({tag, "_count"}, q.size() - base, len);
        for (int i = 0; i < len; i++)
            if (base + i >= q.size() || q[base + i] !== first + 16'(i)) errs++;
        chk({tag, "_order"}, errs, 0);
    endtask

    task automatic full_run(input string tag);
        int n, b_rd, b_hs, b_last, b_done, b_multi, b_q;
        b_rd = rd_cnt; b_hs = hs_cnt; b_last = last_cnt;
        b_done = done_cnt; b_multi = rd_multi; b_q = got.size();
        out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 1;
        chk({tag, "_lat_rd_t1"}, 32'(sram_read_ena), 1);
        chk({tag, "_lat_addr_t1"}, 32'(address), 0);
        chk({tag, "_lat_busy_t1"}, 32'(busy), 1);
        chk({tag, "_lat_valid_t1"}, 32'(out_valid), 0);
        @(posedge clk); #1 n++;
        chk({tag, "_lat_rd_t2"}, 32'(sram_read_ena), 0);
        chk({tag, "_lat_valid_t2"}, 32'(out_valid), 0);
        @(posedge clk); #1 n++;
        chk({tag, "_lat_valid_t3"}, 32'(out_valid), 1);
        chk({tag, "_lat_data_t3"}, 32'(out_data), 0);
        while (done !== 1'b1 && n < 5000) begin
            @(posedge clk); #1 n++;
        end
        chk({tag, "_done_cycles"}, n, 1538);
        chk({tag, "_busy_at_done"}, 32'(busy), 0);
        repeat (3) begin @(posedge clk); #1; end
        chk({tag, "_reads"}, rd_cnt - b_rd, 512);
        chk({tag, "_read_pulses_single"}, rd_multi - b_multi, 0);
        chk({tag, "_handshakes"}, hs_cnt - b_hs, 512);
        chk({tag, "_last_count"}, last_cnt - b_last, 1);
        chk({tag, "_last_value"}, 32'(last_val), 511);
        chk({tag, "_done_count"}, done_cnt - b_done, 1);
        chk({tag, "_addr_after"}, 32'(address), 511);
        chk_seq(tag, got, b_q, 512, 16'd0);
    endtask

    int n, errs, b_rd, b_hs, b_last, b_done, b_q, mark;

    initial begin
        n_rst = 1'b0; start = 1'b0; out_ready = 1'b1; s_start = 1'b0; s_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_read_ena", 32'(sram_read_ena), 0);
        chk("rst_address", 32'(address), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        n_rst = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        chk("idle_no_reads", rd_cnt, 0);
        chk("idle_no_reads_small", s_rd_cnt, 0);

        full_run("a");

        // Backpressure on sample 5, start while busy at sample 100, start during DONE.
        b_rd = rd_cnt; b_hs = hs_cnt; b_last = last_cnt; b_done = done_cnt; b_q = got.size();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (!(out_valid === 1'b1 && out_data === 16'd5) && n < 200) begin
            @(posedge clk); #1 n++;
        end
        chk("b_reach_5", 32'(out_valid === 1'b1 && out_data === 16'd5), 1);
        out_ready = 1'b0;
        mark = rd_cnt;
        errs = 0;
        repeat (7) begin
            @(posedge clk); #1;
            if (!(out_valid === 1'b1 && out_data === 16'd5 && out_last === 1'b0)) errs++;
        end
        chk("b_stall_stable", errs, 0);
        chk("b_stall_no_reads", rd_cnt - mark, 0);
        out_ready = 1'b1;
        n = 0;
        while (!(out_valid === 1'b1 && out_data === 16'd100) && n < 1000) begin
            @(posedge clk); #1 n++;
        end
        chk("b_reach_100", 32'(out_valid === 1'b1 && out_data === 16'd100), 1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("b_restart_ignored_busy", 32'(busy), 1);
        n = 0;
        while (!(out_valid === 1'b1 && out_last === 1'b1) && n < 2000) begin
            @(posedge clk); #1 n++;
        end
        chk("b_reach_last", 32'(out_valid === 1'b1 && out_last === 1'b1), 1);
        chk("b_last_data", 32'(out_data), 511);
        @(posedge clk); #1 start = 1'b1;
        chk("b_done_state_busy", 32'(busy), 1);
        chk("b_done_state_no_done", 32'(done), 0);
        @(posedge clk); #1 start = 1'b0;
        chk("b_done_pulse", 32'(done), 1);
        chk("b_done_busy_low", 32'(busy), 0);
        chk("b_done_no_read", 32'(sram_read_ena), 0);
        @(posedge clk); #1;
        chk("b_start_in_done_ignored", 32'(sram_read_ena), 0);
        chk("b_done_one_cycle", 32'(done), 0);
        chk("b_reads", rd_cnt - b_rd, 512);
        chk("b_handshakes", hs_cnt - b_hs, 512);
        chk("b_last_count", last_cnt - b_last, 1);
        chk("b_done_count", done_cnt - b_done, 1);
        chk_seq("b", got, b_q, 512, 16'd0);

        // Start the cycle after done, then abort with reset while holding sample 300.
        b_rd = rd_cnt; b_hs = hs_cnt; b_done = done_cnt; b_q = got.size();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("c_restart_read", 32'(sram_read_ena), 1);
        chk("c_restart_addr", 32'(address), 0);
        chk("c_restart_busy", 32'(busy), 1);
        n = 0;
        while (!(out_valid === 1'b1 && out_data === 16'd300) && n < 2000) begin
            @(posedge clk); #1 n++;
        end
        chk("c_reach_300", 32'(out_valid === 1'b1 && out_data === 16'd300), 1);
        out_ready = 1'b0;
        @(posedge clk); #2 n_rst = 1'b0;
        #1;
        chk("abort_read_ena", 32'(sram_read_ena), 0);
        chk("abort_address", 32'(address), 0);
        chk("abort_out_data", 32'(out_data), 0);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_out_last", 32'(out_last), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        @(posedge clk); #1 n_rst = 1'b1; out_ready = 1'b1;
        mark = rd_cnt;
        repeat (6) begin @(posedge clk); #1; end
        chk("abort_no_reads", rd_cnt - mark, 0);
        chk("abort_no_done", done_cnt - b_done, 0);
        chk_seq("c", got, b_q, 300, 16'd0);

        full_run("d");

        // DEPTH=4 instance, ready toggling every cycle.
        b_rd = s_rd_cnt; b_hs = s_hs_cnt; b_last = s_last_cnt; b_done = s_done_cnt; b_q = s_got.size();
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0; s_ready = ~s_ready;
        n = 0;
        while (s_done !== 1'b1 && n < 200) begin
            @(posedge clk); #1 s_ready = ~s_ready; n++;
        end
        chk("s_done_seen", 32'(s_done), 1);
        repeat (4) begin @(posedge clk); #1 s_ready = ~s_ready; end
        chk("s_reads", s_rd_cnt - b_rd, 4);
        chk("s_handshakes", s_hs_cnt - b_hs, 4);
        chk("s_last_count", s_last_cnt - b_last, 1);
        chk("s_last_value", 32'(s_last_val), 32'h0000A003);
        chk("s_done_count", s_done_cnt - b_done, 1);
        chk("s_addr_after", 32'(s_address), 3);
        chk_seq("s", s_got, b_q, 4, 16'hA000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
